czono_op_sched: RTL

CZONO_OP_SCHED -- requirements
Module: czono_op_sched

---
 rtl/czono_op_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/czono_op_sched.sv
// Command scheduler for the constrained-zonotope op units: queues {op, tag}
// commands, runs one op at a time on the shared BRAM and returns a tagged status.
module czono_op_sched #(
  parameter int NMAX       = 10,
  parameter int NGMAX      = 5,
  parameter int NCMAX      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [3:0] cmd_tag_i,
  output logic       plus_start_o,
  output logic       image_start_o,
  output logic       isect_start_o,
  input  logic       plus_done_i,
  input  logic       image_done_i,
  input  logic       isect_done_i,
  output logic [1:0] ram_sel_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [3:0] rsp_tag_o,
  output logic [1:0] rsp_status_o,
  output logic       busy_o,
  output logic [7:0] err_cnt_o,
  output logic [1:0] dbg_state_o
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  // An illegal parameter set keeps the command port closed instead of misbehaving.
  localparam logic PARAM_OK = (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                              (TIMEOUT >= 2) && (NMAX >= 1) && (NGMAX >= 1) && (NCMAX >= 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_OP  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] SEL_NONE   = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  // Valid/ready: a command moves on an edge where cmd_valid_i && cmd_ready_o;
  // a response moves on an edge where rsp_valid_o && rsp_ready_i, and until then
  // rsp_tag_o/rsp_status_o are held stable.

  logic [5:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          rdy_en_q, rdy_en_d;
  logic          push, pop, full;
  logic [5:0]    head;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    tag_q, tag_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    start_q, start_d;
  logic [1:0]    ram_sel_q, ram_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [3:0]    rsp_tag_q, rsp_tag_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic [7:0]    err_q, err_d;
  logic          sel_done;

  assign full        = (cnt_q == CNT_FULL);
  assign cmd_ready_o = rdy_en_q & ~full;
  assign push        = cmd_valid_i & cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && (cnt_q != '0);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    rdy_en_d = PARAM_OK;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (PW + 1)'(1);
    if (pop && !push) cnt_d = cnt_q - (PW + 1)'(1);
  end

  always_comb begin
    sel_done = 1'b0;
    case (op_q)
      2'd0:    sel_done = plus_done_i;
      2'd1:    sel_done = image_done_i;
      2'd2:    sel_done = isect_done_i;
      default: sel_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    timer_d      = timer_q;
    start_d      = 3'b000;
    ram_sel_d    = ram_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_status_d = rsp_status_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_d  = head[5:4];
          tag_d = head[3:0];
          if (head[5:4] != 2'd3) begin
            state_d   = S_START;
            start_d   = 3'(3'b001 << head[5:4]);
            ram_sel_d = head[5:4];
          end else begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_tag_d    = head[3:0];
            rsp_status_d = ST_BAD_OP;
          end
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over a timeout landing on the same cycle.
        if (sel_done || (timer_q == T_LAST)) begin
          state_d      = S_RESP;
          ram_sel_d    = SEL_NONE;
          rsp_valid_d  = 1'b1;
          rsp_tag_d    = tag_q;
          rsp_status_d = sel_done ? ST_OK : ST_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          if ((rsp_status_q != ST_OK) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op_i, cmd_tag_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rdy_en_q     <= 1'b0;
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      tag_q        <= 4'd0;
      timer_q      <= '0;
      start_q      <= 3'b000;
      ram_sel_q    <= SEL_NONE;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= 4'd0;
      rsp_status_q <= 2'd0;
      err_q        <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rdy_en_q     <= rdy_en_d;
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      timer_q      <= timer_d;
      start_q      <= start_d;
      ram_sel_q    <= ram_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_status_q <= rsp_status_d;
      err_q        <= err_d;
    end
  end

  assign plus_start_o  = start_q[0];
  assign image_start_o = start_q[1];
  assign isect_start_o = start_q[2];
  assign ram_sel_o     = ram_sel_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_tag_o     = rsp_tag_q;
  assign rsp_status_o  = rsp_status_q;
  assign busy_o        = (state_q != S_IDLE) || (cnt_q != '0);
  assign err_cnt_o     = err_q;
  assign dbg_state_o   = state_q;

endmodule
